k580vi53_bus_sched: RTL and testbench

//  Owns the bus port of the k580vi53 interval timer and shares it between the CPU and an

---
 rtl/k580vi53_bus_sched.sv | 172 +++++++++++++++++
 tb/tb_k580vi53_bus_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/k580vi53_bus_sched.sv
// Bus owner for the k580vi53 timer: CPU pass-through plus an atomic CW/LSB/MSB programming sequencer.
// Optional boot-time channel initialisation is enabled by defining PIT_BOOT_INIT_EN.
module k580vi53_bus_sched #(
  parameter logic [7:0]  INIT_CW0  = 8'h36,
  parameter logic [7:0]  INIT_CW1  = 8'h76,
  parameter logic [7:0]  INIT_CW2  = 8'hB6,
  parameter logic [15:0] INIT_CNT0 = 16'h0000,
  parameter logic [15:0] INIT_CNT1 = 16'h0000,
  parameter logic [15:0] INIT_CNT2 = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  input  logic        req_valid,
  input  logic [1:0]  req_ch,
  input  logic [2:0]  req_mode,
  input  logic [15:0] req_count,
  output logic        req_ready,
  output logic        seq_done,
  output logic        boot_busy,
  output logic [1:0]  pit_addr,
  output logic        pit_rd,
  output logic        pit_we_n,
  output logic [7:0]  pit_idata,
  input  logic [7:0]  pit_odata
);

  typedef enum logic [1:0] {BOOT, IDLE, WR_LO, WR_HI} state_t;

`ifdef PIT_BOOT_INIT_EN
  localparam state_t RST_STATE = BOOT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t      state, state_nxt;
  logic [4:0]  boot_cnt, boot_cnt_nxt;
  logic [1:0]  wr_idx, wr_idx_nxt;
  logic        done_r, done_nxt;
  logic        strobe_prev;
  logic        cpu_strobe;
  logic        accept;
  logic [1:0]  ch_r;
  logic [2:0]  mode_r;
  logic [15:0] cnt_r;

  // Boot write n (0..8): three writes per channel, control word then LSB then MSB.
  function automatic logic [9:0] boot_write(input logic [3:0] n);
    case (n)
      4'd0:    return {2'd3, INIT_CW0};
      4'd1:    return {2'd0, INIT_CNT0[7:0]};
      4'd2:    return {2'd0, INIT_CNT0[15:8]};
      4'd3:    return {2'd3, INIT_CW1};
      4'd4:    return {2'd1, INIT_CNT1[7:0]};
      4'd5:    return {2'd1, INIT_CNT1[15:8]};
      4'd6:    return {2'd3, INIT_CW2};
      4'd7:    return {2'd2, INIT_CNT2[7:0]};
      default: return {2'd2, INIT_CNT2[15:8]};
    endcase
  endfunction

  function automatic logic [9:0] seq_write(input logic [1:0] idx);
    case (idx)
      2'd0:    return {2'd3, ch_r, 2'b11, mode_r, 1'b0};
      2'd1:    return {ch_r, cnt_r[7:0]};
      default: return {ch_r, cnt_r[15:8]};
    endcase
  endfunction

  assign cpu_strobe = cpu_rd | cpu_wr;
  assign cpu_rdata  = pit_odata;
  assign accept     = req_valid & req_ready;
  assign seq_done   = done_r & ~reset;

`ifdef PIT_BOOT_INIT_EN
  assign boot_busy = (state == BOOT) & ~reset;
`else
  assign boot_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RST_STATE;
      boot_cnt    <= 5'd0;
      wr_idx      <= 2'd0;
      done_r      <= 1'b0;
      strobe_prev <= 1'b0;
    end else begin
      state       <= state_nxt;
      boot_cnt    <= boot_cnt_nxt;
      wr_idx      <= wr_idx_nxt;
      done_r      <= done_nxt;
      strobe_prev <= cpu_strobe;
    end
  end

  // Request fields are data only; they are qualified by the state machine.
  always_ff @(posedge clk) begin
    if (accept) begin
      ch_r   <= req_ch;
      mode_r <= req_mode;
      cnt_r  <= req_count;
    end
  end

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    wr_idx_nxt   = wr_idx;
    done_nxt     = 1'b0;
    pit_addr     = 2'd0;
    pit_rd       = 1'b0;
    pit_we_n     = 1'b1;
    pit_idata    = 8'd0;
    cpu_wait     = 1'b0;
    req_ready    = 1'b0;
    if (!reset) begin
      case (state)
        BOOT: begin
          {pit_addr, pit_idata} = boot_write(boot_cnt[4:1]);
          pit_we_n = boot_cnt[0];
          cpu_wait = cpu_strobe;
          if (boot_cnt == 5'd17) begin
            boot_cnt_nxt = 5'd0;
            state_nxt    = IDLE;
          end else begin
            boot_cnt_nxt = boot_cnt + 5'd1;
          end
        end
        IDLE: begin
          pit_addr  = cpu_addr;
          pit_rd    = cpu_rd;
          pit_we_n  = ~cpu_wr;
          pit_idata = cpu_wdata;
          // A quiet previous cycle guarantees the timer has seen we_n high before our first write.
          req_ready = ~cpu_strobe & ~strobe_prev;
          if (req_valid && req_ready) begin
            if (req_ch == 2'd3) begin
              done_nxt = 1'b1;
            end else begin
              wr_idx_nxt = 2'd0;
              state_nxt  = WR_LO;
            end
          end
        end
        WR_LO: begin
          {pit_addr, pit_idata} = seq_write(wr_idx);
          pit_we_n  = 1'b0;
          cpu_wait  = cpu_strobe;
          state_nxt = WR_HI;
        end
        default: begin
          {pit_addr, pit_idata} = seq_write(wr_idx);
          cpu_wait = cpu_strobe;
          if (wr_idx == 2'd2) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            wr_idx_nxt = wr_idx + 2'd1;
            state_nxt  = WR_LO;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k580vi53_bus_sched.sv
// Self-checking bench for k580vi53_bus_sched: write-log/timing model plus directed literal checks.
// Boot expectations follow PIT_BOOT_INIT_EN the same way the design does.
module tb_k580vi53_bus_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_wait;
  logic        req_valid;
  logic [1:0]  req_ch;
  logic [2:0]  req_mode;
  logic [15:0] req_count;
  logic        req_ready, seq_done, boot_busy;
  logic [1:0]  pit_addr;
  logic        pit_rd, pit_we_n;
  logic [7:0]  pit_idata, pit_odata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  k580vi53_bus_sched dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .req_valid(req_valid), .req_ch(req_ch), .req_mode(req_mode), .req_count(req_count),
    .req_ready(req_ready), .seq_done(seq_done), .boot_busy(boot_busy),
    .pit_addr(pit_addr), .pit_rd(pit_rd), .pit_we_n(pit_we_n),
    .pit_idata(pit_idata), .pit_odata(pit_odata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: bus windows owned by the sequencer and the writes expected inside them.
  logic [9:0] exp_q[$];
  logic [9:0] held;
  int         busy_start = 0;
  int         busy_end   = -1;
  int         done_due   = -1;
  logic       boot_win   = 1'b0;
  logic       prev_strobe_m = 1'b0;

  task automatic push3(input logic [1:0] ch, input logic [7:0] cw, input logic [15:0] cnt);
    exp_q.push_back({2'd3, cw});
    exp_q.push_back({ch, cnt[7:0]});
    exp_q.push_back({ch, cnt[15:8]});
  endtask

  always @(negedge clk) begin : compare
    logic strobe, busy_m, exp_rdy, we_exp, done_exp;
    strobe = cpu_rd | cpu_wr;
    if (reset) begin
      chk("rst_we_n", pit_we_n, 1);
      chk("rst_rd", pit_rd, 0);
      chk("rst_addr", pit_addr, 0);
      chk("rst_idata", pit_idata, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_done", seq_done, 0);
      chk("rst_wait", cpu_wait, 0);
      exp_q.delete();
      done_due = -1;
      busy_end = -1;
      boot_win = 1'b0;
`ifdef PIT_BOOT_INIT_EN
      boot_win   = 1'b1;
      busy_start = cyc + 1;
      busy_end   = cyc + 18;
      push3(2'd0, 8'h36, 16'h0000);
      push3(2'd1, 8'h76, 16'h0000);
      push3(2'd2, 8'hB6, 16'h0000);
`endif
    end else begin
      busy_m   = (cyc >= busy_start) && (cyc <= busy_end);
      done_exp = (cyc == done_due);
      chk("boot_busy", boot_busy, busy_m & boot_win);
      chk("rdata", cpu_rdata, pit_odata);
      chk("seq_done", seq_done, done_exp);
      if (busy_m) begin
        chk("busy_wait", cpu_wait, strobe);
        chk("busy_rd", pit_rd, 0);
        chk("busy_ready", req_ready, 0);
        if (((cyc - busy_start) % 2) == 0) begin
          chk("wr_we_n_low", pit_we_n, 0);
          chk("exp_q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) held = exp_q.pop_front();
          chk("wr_addr", pit_addr, held[9:8]);
          chk("wr_data", pit_idata, held[7:0]);
        end else begin
          chk("hold_we_n_high", pit_we_n, 1);
          chk("hold_addr_data", {pit_addr, pit_idata}, held);
        end
      end else begin
        we_exp  = ~cpu_wr;
        exp_rdy = ~strobe & ~prev_strobe_m;
        chk("idle_wait", cpu_wait, 0);
        chk("pt_addr", pit_addr, cpu_addr);
        chk("pt_rd", pit_rd, cpu_rd);
        chk("pt_we_n", pit_we_n, we_exp);
        chk("pt_idata", pit_idata, cpu_wdata);
        chk("req_ready", req_ready, exp_rdy);
        if (req_valid && exp_rdy) begin
          if (req_ch == 2'd3) begin
            done_due = cyc + 1;
          end else begin
            boot_win   = 1'b0;
            busy_start = cyc + 1;
            busy_end   = cyc + 6;
            done_due   = cyc + 7;
            push3(req_ch, {req_ch, 2'b11, req_mode, 1'b0}, req_count);
          end
        end
      end
    end
    prev_strobe_m = reset ? 1'b0 : strobe;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int acc);
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    chk("ready_timeout", acc >= 0, 1);
  endtask

  int a;

  initial begin
    reset = 1'b1; cpu_addr = 2'd0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    req_valid = 1'b0; req_ch = 2'd0; req_mode = 3'd0; req_count = 16'h0000; pit_odata = 8'h3C;
    repeat (3) nxt();
    reset = 1'b0;
    // T1: boot (or direct IDLE in the default build)
    @(negedge clk);
`ifdef PIT_BOOT_INIT_EN
    chk("t1_first_addr", pit_addr, 3);
    chk("t1_first_data", pit_idata, 8'h36);
    chk("t1_first_we_n", pit_we_n, 0);
    chk("t1_busy_start", boot_busy, 1);
    repeat (17) @(negedge clk);
    chk("t1_busy_last", boot_busy, 1);
    @(negedge clk);
    chk("t1_busy_drop", boot_busy, 0);
`else
    chk("t1_no_boot_busy", boot_busy, 0);
    chk("t1_ready_now", req_ready, 1);
`endif
    // T2 + T3: tone load with a CPU write arriving mid-sequence
    nxt();
    req_valid = 1'b1; req_ch = 2'd1; req_mode = 3'd3; req_count = 16'h1234;
    wait_ready(a);
    nxt(); req_valid = 1'b0;
    @(negedge clk);
    chk("t2_w1_addr", pit_addr, 3);
    chk("t2_w1_data", pit_idata, 8'h76);
    nxt();
    nxt(); cpu_wr = 1'b1; cpu_addr = 2'd0; cpu_wdata = 8'h55;
    @(negedge clk);
    chk("t3_wait_high", cpu_wait, 1);
    chk("t2_w2_data", {pit_addr, pit_idata}, {2'd1, 8'h34});
    nxt();
    nxt();
    @(negedge clk);
    chk("t2_w3_data", {pit_addr, pit_idata}, {2'd1, 8'h12});
    nxt();
    @(negedge clk);
    chk("t2_done_early", seq_done, 0);
    nxt();
    @(negedge clk);
    chk("t2_done_pulse", seq_done, 1);
    chk("t3_wait_low", cpu_wait, 0);
    chk("t3_fwd", {pit_we_n, pit_addr, pit_idata}, {1'b0, 2'd0, 8'h55});
    nxt(); cpu_wr = 1'b0;
    nxt();
    nxt();
    // T4: CPU read in IDLE blocks a waiting request
    cpu_rd = 1'b1; cpu_addr = 2'd2; pit_odata = 8'hA5;
    req_valid = 1'b1; req_ch = 2'd0; req_mode = 3'd2; req_count = 16'hBEEF;
    @(negedge clk);
    chk("t4_rd", pit_rd, 1);
    chk("t4_rdata", cpu_rdata, 8'hA5);
    chk("t4_addr", pit_addr, 2);
    chk("t4_ready", req_ready, 0);
    nxt(); cpu_rd = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_rd", req_ready, 0);
    nxt();
    // T5: reset during the second write of a sequence
    wait_ready(a);
    nxt(); req_valid = 1'b0;
    nxt();
    nxt(); reset = 1'b1;
    @(negedge clk);
    chk("t5_we_n_now", pit_we_n, 1);
    nxt();
    @(negedge clk);
    chk("t5_we_n_next", pit_we_n, 1);
    nxt(); reset = 1'b0;
    @(negedge clk);
`ifdef PIT_BOOT_INIT_EN
    chk("t5_reboot", {boot_busy, pit_we_n, pit_addr, pit_idata}, {1'b1, 1'b0, 2'd3, 8'h36});
`else
    chk("t5_idle", {boot_busy, req_ready}, {1'b0, 1'b1});
`endif
    // T6: invalid channel
    nxt();
    req_valid = 1'b1; req_ch = 2'd3; req_mode = 3'd1; req_count = 16'h0F0F;
    wait_ready(a);
    chk("t6_we_n", pit_we_n, 1);
    nxt(); req_valid = 1'b0;
    @(negedge clk);
    chk("t6_done", seq_done, 1);
    chk("t6_we_n_after", pit_we_n, 1);
    repeat (4) nxt();
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
